// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling swap phase: walks i over 0..255, updates j from s[i] and the key,
// and swaps s[i]/s[j] through a single-port S-RAM with one-cycle read latency.
module ksa_shuffle #(
  parameter int KEY_LEN = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8*KEY_LEN-1:0] secret_key,
  output logic [7:0]           s_address,
  output logic [7:0]           s_data,
  output logic                 s_write_enable,
  input  logic [7:0]           s_q,
  output logic                 busy,
  output logic                 done
);

  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [KW-1:0] KEY_LAST = KW'(KEY_LEN - 1);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_READ_I  = 4'd1;
  localparam logic [3:0] ST_LATCH_I = 4'd2;
  localparam logic [3:0] ST_READ_J  = 4'd3;
  localparam logic [3:0] ST_LATCH_J = 4'd4;
  localparam logic [3:0] ST_WRITE_I = 4'd5;
  localparam logic [3:0] ST_WRITE_J = 4'd6;
  localparam logic [3:0] ST_INCR    = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;

  logic [3:0]           r_state;
  logic [7:0]           r_i;
  logic [7:0]           r_j;
  logic [7:0]           r_si;
  logic [7:0]           r_sj;
  logic [8*KEY_LEN-1:0] r_key;
  logic [KW-1:0]        r_kidx;
  logic [7:0]           w_key_byte;

  // Key byte k lives in the MSB-first position; a small mux replaces i mod KEY_LEN.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_key_byte = 8'h00;
    for (int k = 0; k < KEY_LEN; k++) begin
      if (r_kidx == KW'(k)) w_key_byte = r_key[8*(KEY_LEN-k)-1 -: 8];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    if (reset) begin
      r_state <= ST_IDLE;
      r_i     <= 8'h00;
      r_j     <= 8'h00;
      r_si    <= 8'h00;
      r_sj    <= 8'h00;
      r_key   <= '0;
      r_kidx  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_READ_I;
            r_i     <= 8'h00;
            r_j     <= 8'h00;
            r_kidx  <= '0;
            r_key   <= secret_key;
          end
        end
        ST_READ_I:  r_state <= ST_LATCH_I;
        ST_LATCH_I: begin
          r_si    <= s_q;
          r_j     <= r_j + s_q + w_key_byte;
          r_state <= ST_READ_J;
        end
        ST_READ_J:  r_state <= ST_LATCH_J;
        ST_LATCH_J: begin
          r_sj    <= s_q;
          r_state <= ST_WRITE_I;
        end
        ST_WRITE_I: r_state <= ST_WRITE_J;
        ST_WRITE_J: r_state <= ST_INCR;
        ST_INCR: begin
          if (r_i == 8'hFF) begin
            r_state <= ST_DONE;
          end else begin
            r_i     <= r_i + 8'h01;
            r_kidx  <= (r_kidx == KEY_LAST) ? '0 : r_kidx + KW'(1);
            r_state <= ST_READ_I;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM bus is decoded from state and registers only; reset forces it quiet immediately.
  always_comb begin
    s_address      = 8'h00;
    s_data         = 8'h00;
    s_write_enable = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_READ_I: s_address = r_i;
        ST_READ_J: s_address = r_j;
        ST_WRITE_I: begin
          s_address      = r_i;
          s_data         = r_sj;
          s_write_enable = 1'b1;
        end
        ST_WRITE_J: begin
          s_address      = r_j;
          s_data         = r_si;
          s_write_enable = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_ksa_shuffle.sv
// Self-checking bench for ksa_shuffle: behavioural S-RAM, software KSA reference,
// table-driven key vectors plus start-while-busy, mid-run reset and re-start sequences.
`timescale 1ns/1ps
module tb_ksa_shuffle;

  localparam int KEY_LEN    = 3;
  localparam int RUN_CYCLES = 1792;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  s_address;
  logic [7:0]  s_data;
  logic        s_write_enable;
  logic [7:0]  s_q;
  logic        busy;
  logic        done;

  ksa_shuffle #(.KEY_LEN(KEY_LEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .secret_key     (secret_key),
    .s_address      (s_address),
    .s_data         (s_data),
    .s_write_enable (s_write_enable),
    .s_q            (s_q),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with one-cycle read latency; init_req loads s[k]=k.
  logic [7:0] mem [256];
  logic       init_req = 1'b0;
  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (s_write_enable) begin
      mem[s_address] <= s_data;
    end
    s_q <= mem[s_address];
  end

  logic [7:0] wlog_a [$];
  logic [7:0] wlog_d [$];
  always @(negedge clk) begin
    if (s_write_enable) begin
      wlog_a.push_back(s_address);
      wlog_d.push_back(s_data);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: textbook RC4 KSA, recording the (address, data) pair of every write.
  int model_s [256];
  int exp_a [$];
  int exp_d [$];
  task automatic model_ksa(input logic [23:0] key);
    int j;
    int t;
    int kb;
    exp_a.delete();
    exp_d.delete();
    for (int k = 0; k < 256; k++) model_s[k] = k;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = int'((key >> (8 * (KEY_LEN - 1 - (i % KEY_LEN)))) & 24'hFF);
      j = (j + model_s[i] + kb) % 256;
      exp_a.push_back(i);
      exp_d.push_back(model_s[j]);
      exp_a.push_back(j);
      exp_d.push_back(model_s[i]);
      t = model_s[i];
      model_s[i] = model_s[j];
      model_s[j] = t;
    end
  endtask

  task automatic init_ram();
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  // One shuffle; perturb_at pulses start with a different key mid-run, reset_at aborts.
  task automatic run(input logic [23:0] key, input int perturb_at, input int reset_at,
                     input string name);
    int  c;
    int  lat;
    int  bad;
    init_ram();
    model_ksa(key);
    wlog_a.delete();
    wlog_d.delete();
    @(negedge clk);
    secret_key = key;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, " busy_after_start"}, int'(busy), 1);
    check({name, " done_after_start"}, int'(done), 0);
    lat = -1;
    for (c = 1; c <= RUN_CYCLES + 20; c++) begin
      @(posedge clk);
      #1;
      start = (c == perturb_at);
      if (c == perturb_at) secret_key = ~key;
      if (c == reset_at) begin
        reset = 1'b1;
        check({name, " we_in_reset_cycle"}, int'(s_write_enable), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check({name, " busy_after_reset"}, int'(busy), 0);
        check({name, " done_after_reset"}, int'(done), 0);
        check({name, " we_after_reset"}, int'(s_write_enable), 0);
        check({name, " addr_after_reset"}, int'(s_address), 0);
        return;
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    check({name, " done_latency"}, lat, RUN_CYCLES);
    check({name, " write_count"}, wlog_a.size(), 512);
    bad = 0;
    for (int k = 0; k < wlog_a.size() && k < exp_a.size(); k++) begin
      if (int'(wlog_a[k]) != exp_a[k] || int'(wlog_d[k]) != exp_d[k]) bad++;
    end
    check({name, " write_sequence_mismatches"}, bad, 0);
    bad = 0;
    for (int k = 0; k < 256; k++) if (int'(mem[k]) != model_s[k]) bad++;
    check({name, " final_ram_mismatches"}, bad, 0);
    check({name, " done_idle_bus"}, int'({s_address, s_data, s_write_enable, busy}), 0);
  endtask

  typedef struct {
    string       name;
    logic [23:0] key;
    int          a0, d0, a1, d1;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] rkey;
    int          nw;
    int          held;

    vecs[0] = '{name: "key000000", key: 24'h000000, a0: 0, d0: 0,   a1: 0,   d1: 0};
    vecs[1] = '{name: "key010203", key: 24'h010203, a0: 0, d0: 1,   a1: 1,   d1: 0};
    vecs[2] = '{name: "keyFFFFFF", key: 24'hFFFFFF, a0: 0, d0: 255, a1: 255, d1: 0};
    vecs[3] = '{name: "key800000", key: 24'h800000, a0: 0, d0: 128, a1: 128, d1: 0};

    reset      = 1'b1;
    start      = 1'b0;
    secret_key = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({s_address, s_data, s_write_enable, busy, done}), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_we", int'(s_write_enable), 0);
    check("post_reset_busy_done", int'({busy, done}), 0);

    foreach (vecs[v]) begin
      run(vecs[v].key, -1, -1, vecs[v].name);
      if (wlog_a.size() >= 2) begin
        check({vecs[v].name, " first_write_addr"}, int'(wlog_a[0]), vecs[v].a0);
        check({vecs[v].name, " first_write_data"}, int'(wlog_d[0]), vecs[v].d0);
        check({vecs[v].name, " second_write_addr"}, int'(wlog_a[1]), vecs[v].a1);
        check({vecs[v].name, " second_write_data"}, int'(wlog_d[1]), vecs[v].d1);
      end else begin
        check({vecs[v].name, " first_writes_present"}, wlog_a.size(), 2);
      end
      if (v == 0 && wlog_a.size() >= 6) begin
        // Third iteration of the zero key: j=3, so s[2]=3 then s[3]=2.
        check("key000000 iter2_addr_i", int'(wlog_a[4]), 2);
        check("key000000 iter2_data_i", int'(wlog_d[4]), 3);
        check("key000000 iter2_addr_j", int'(wlog_a[5]), 3);
        check("key000000 iter2_data_j", int'(wlog_d[5]), 2);
      end
    end

    for (int r = 0; r < 2; r++) begin
      rkey = 24'($urandom);
      run(rkey, -1, -1, $sformatf("random%0d_%06h", r, rkey));
    end

    // Key change and start pulse during iteration 50 must leave the run untouched.
    run(24'h010203, 50 * 7 + 2, -1, "start_while_busy");

    // Reset in LATCH_J of i=100, then a clean rerun.
    run(24'h123456, -1, 100 * 7 + 3, "reset_mid");
    run(24'h010203, -1, -1, "after_reset");

    nw   = wlog_a.size();
    held = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done) held++;
    end
    check("done_hold_cycles", held, 20);
    check("done_hold_no_writes", wlog_a.size(), nw);

    run(24'hA5C3E1, -1, -1, "restart_from_done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
